laser500_scandoubler: RTL and testbench
=======================================

# laser500_scandoubler

Line-doubling video stage between the VTL chip video outputs and the OSD overlay. It converts the 15.6 kHz Laser 500 RGB stream into a 31.2 kHz stream for VGA monitors. Each input line is captured into a ping-pong line buffer and replayed twice at double pixel rate. The second replay can optionally be darkened to produce scanlines.

## Interface
Parameters:
- COLOR_W, 6, bits per colour component.
- HLEN_MAX, 1024, line buffer depth in pixels; must be a power of 2.

Ports:
- CLK, in, 1: 2× pixel clock, 29.55746 MHz (PLL, twice F14M).
- RESET, in, 1: reset, synchronous, active-low.
- ce_pix, in, 1: input pixel strobe, one CLK pulse every other cycle.
- hs_in, in, 1: input hsync, active-low, sampled on ce_pix.
- vs_in, in, 1: input vsync, active-low, sampled on ce_pix.
- r_in, g_in, b_in, in, COLOR_W each: input pixel, sampled on ce_pix.
- scanlines, in, 1: 1 = darken the second replay of each line.
- hs_out, out, 1: output hsync, active-low.
- vs_out, out, 1: output vsync, active-low.
- r_out, g_out, b_out, out, COLOR_W each: output pixel.
- line_len, out, log2(HLEN_MAX): measured input line length in pixels.

## Operation
**Write side (on ce_pix only)**
- Pixel {r,g,b} is written to bank `wbank` at address `wr_x`, then `wr_x` increments.
- `wr_x` saturates at HLEN_MAX-1. Once saturated, further writes are dropped (write enable off).
- `hsw_cnt` counts ce_pix strobes while hs_in = 0, saturating at HLEN_MAX-1.

**Line boundary**
- The line boundary is the hs_in falling edge, seen as the previous sampled hs_in = 1 and the current one = 0 on a ce_pix.
- At the boundary:
  - `line_len` ← `wr_x` (saturated value).
  - `hs_width` ← last completed `hsw_cnt`.
  - `wr_x` ← 0.
  - `rbank` ← `wbank`, then `wbank` toggles.
  - `vs_out_n` ← sampled vs_in.
  - Read side restarts: `rd_x` ← 0, `phase` ← 0.

**Read side (every CLK)**
- `rd_x` increments every cycle.
- When `rd_x` = `line_len`-1:
  - If `phase` = 0: `rd_x` ← 0, `phase` ← 1.
  - If `phase` = 1: `rd_x` holds at `line_len`-1 until the next boundary.
- The boundary always overrides read-side increments in the same cycle.
- hs_out is low while `rd_x` < `hs_width`. The output sync width is therefore half the input sync duration.
- Idle state: while `line_len` = 0 (no complete line since reset), hs_out = 1 and RGB = 0.

**Scanlines**
- When `phase` = 1 and scanlines = 1, each component is output as {1'b0, c[COLOR_W-1:1]}.
- Otherwise the component passes unmodified.
- scanlines is sampled per pixel, so toggling it takes effect on the next pixel.

## Timing
- Reset (RESET = 0 at a CLK edge):
  - hs_out = 1, vs_out = 1, RGB = 0, line_len = 0.
  - `wr_x` = `rd_x` = 0, `phase` = 0, `wbank` = 0, `rbank` = 1, previous-hs sample = 1.
  - Reset mid-line discards the partial line. The first boundary after release is only a start marker: `line_len` reflects a full line only after the second boundary.
- Read pipeline:
  - `rd_x`/`rbank` → RAM registered read (1 cycle) → scanline mux plus output register (1 cycle).
  - RGB lags `rd_x` by 2 CLK.
  - hs_out is derived from `rd_x` and delayed by 2 CLK so it aligns with RGB.
- vs_out changes 2 CLK after the boundary cycle.
- Steady state: input line of N pixels = 2N CLK = two replays of N CLK each. No drift, because every boundary resynchronises the read side.
- A write and a read never hit the same bank in the same line.

## Structure
- Package `laser500_video_pkg`:
  - constants COLOR_W, HLEN_MAX, HADDR_W = $clog2(HLEN_MAX);
  - typedef `rgb_t` (struct of three COLOR_W fields);
  - function `scanline_dim(rgb_t)`.
- Sub-module `scandoubler_linebuf`: simple dual-port RAM, 2×HLEN_MAX × 3·COLOR_W.
  - Port A: write, address {wbank, wr_x}.
  - Port B: registered read, address {rbank, rd_x}.
  - Infers as M9K.
- Top level holds the write counters, the boundary detector, the read FSM (`phase` 0/1 plus the hold condition) and the output pipeline.

## Test plan
- **Reset:** hold RESET = 0 for 4 CLK mid-stream → hs_out = 1, vs_out = 1, RGB = 0, line_len = 0. After release, before the second hs_in falling edge: outputs stay idle.
- **Steady state:** lines of 946 ce_pix, hs_in low for 70, pixel x = x[5:0] on all components →
  - line_len = 946;
  - per input line, two output lines of 946 CLK;
  - hs_out low for 70 CLK at the start of each replay;
  - RGB at cycle k+2 = k[5:0].
- **Scanlines:** constant 0x3F input, scanlines = 1 → first replay 0x3F, second replay 0x1F. With scanlines = 0, both replays are 0x3F.
- **Overlong line:** 1200-pixel line → line_len = 1023; the second replay holds the last pixel until the boundary; no write wraps into address 0.
- **Vsync:** vs_in = 0 sampled at the boundary of line N → vs_out = 0 exactly 2 CLK after that boundary cycle, and back to 1 two CLK after the first boundary with vs_in = 1.
- **Short line resync:** a 500-pixel line inserted between 946-pixel lines → line_len = 500. The read side restarts at `rd_x` = 0 on the boundary, and the next replay has the correct content.

Source files
------------

// File: rtl/laser500_video_pkg.sv
// rtl/laser500_video_pkg.sv - shared video constants, pixel type and read-side states
package laser500_video_pkg;

  localparam int COLOR_W  = 6;
  localparam int HLEN_MAX = 1024;
  localparam int HADDR_W  = $clog2(HLEN_MAX);

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  // RD_HOLD parks the second replay on its last pixel until the next input line starts
  typedef enum logic [1:0] {
    RD_FIRST,
    RD_SECOND,
    RD_HOLD
  } rd_state_t;

  function automatic rgb_t scanline_dim(rgb_t c);
    rgb_t d;
    d.r = {1'b0, c.r[COLOR_W-1:1]};
    d.g = {1'b0, c.g[COLOR_W-1:1]};
    d.b = {1'b0, c.b[COLOR_W-1:1]};
    return d;
  endfunction

endpackage

// File: rtl/scandoubler_linebuf.sv
// rtl/scandoubler_linebuf.sv - ping-pong line buffer, one write port and one registered read port
module scandoubler_linebuf
  import laser500_video_pkg::*;
#(
  parameter int ADDR_W = HADDR_W + 1,
  parameter int DATA_W = 3 * COLOR_W
) (
  input  logic              CLK,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge CLK) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/laser500_scandoubler.sv
// rtl/laser500_scandoubler.sv - 15.6 kHz to 31.2 kHz line doubler with optional scanlines
module laser500_scandoubler #(
  parameter int COLOR_W  = laser500_video_pkg::COLOR_W,
  parameter int HLEN_MAX = laser500_video_pkg::HLEN_MAX
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        ce_pix,
  input  logic                        hs_in,
  input  logic                        vs_in,
  input  logic [COLOR_W-1:0]          r_in,
  input  logic [COLOR_W-1:0]          g_in,
  input  logic [COLOR_W-1:0]          b_in,
  input  logic                        scanlines,
  output logic                        hs_out,
  output logic                        vs_out,
  output logic [COLOR_W-1:0]          r_out,
  output logic [COLOR_W-1:0]          g_out,
  output logic [COLOR_W-1:0]          b_out,
  output logic [$clog2(HLEN_MAX)-1:0] line_len
);
  import laser500_video_pkg::*;

  localparam int            AW    = $clog2(HLEN_MAX);
  localparam logic [AW-1:0] X_MAX = AW'(HLEN_MAX - 1);
  localparam logic [AW-1:0] X_ONE = AW'(1);

  logic          hs_prev;
  logic          started;
  logic          wbank;
  logic          rbank;
  logic [AW-1:0] wr_x;
  logic [AW-1:0] hsw_cnt;
  logic [AW-1:0] hs_width;
  logic          vs_cap;
  logic          boundary;

  logic          wr_en;
  logic [AW:0]   wr_addr;
  logic [AW:0]   rd_addr;
  logic [3*COLOR_W-1:0] rd_data;

  rd_state_t     rd_state, rd_state_nx;
  logic [AW-1:0] rd_x, rd_x_nx;
  logic [AW-1:0] rd_last;
  logic          phase;
  logic          line_active;

  logic          vld_d1;
  logic          ph_d1;
  logic          hs_d1;
  logic          vs_d1;
  rgb_t          rgb_o;

  assign boundary = ce_pix & hs_prev & ~hs_in;

  // The boundary pixel opens the new line at address 0 of the bank about to become wbank.
  // Nothing is stored before the first boundary, so that boundary yields line_len = 0.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      hs_prev  <= 1'b1;
      started  <= 1'b0;
      wbank    <= 1'b0;
      rbank    <= 1'b1;
      wr_x     <= '0;
      hsw_cnt  <= '0;
      hs_width <= '0;
      vs_cap   <= 1'b1;
      line_len <= '0;
    end else if (ce_pix) begin
      hs_prev <= hs_in;
      if (boundary) begin
        line_len <= wr_x;
        hs_width <= hsw_cnt;
        wr_x     <= X_ONE;
        hsw_cnt  <= X_ONE;
        rbank    <= wbank;
        wbank    <= ~wbank;
        vs_cap   <= vs_in;
        started  <= 1'b1;
      end else begin
        if (started && wr_x != X_MAX) begin
          wr_x <= wr_x + X_ONE;
        end
        if (!hs_in && hsw_cnt != X_MAX) begin
          hsw_cnt <= hsw_cnt + X_ONE;
        end
      end
    end
  end

  assign wr_en   = RESET & ce_pix & (boundary | (started & (wr_x != X_MAX)));
  assign wr_addr = boundary ? {~wbank, {AW{1'b0}}} : {wbank, wr_x};
  assign rd_addr = {rbank, rd_x};

  scandoubler_linebuf #(
    .ADDR_W (AW + 1),
    .DATA_W (3 * COLOR_W)
  ) u_linebuf (
    .CLK     (CLK),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data ({r_in, g_in, b_in}),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign rd_last     = line_len - X_ONE;
  assign phase       = (rd_state != RD_FIRST);
  assign line_active = (line_len != '0);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rd_state <= RD_FIRST;
      rd_x     <= '0;
    end else begin
      rd_state <= rd_state_nx;
      rd_x     <= rd_x_nx;
    end
  end

  always_comb begin
    rd_state_nx = rd_state;
    rd_x_nx     = rd_x + X_ONE;
    if (boundary) begin
      rd_state_nx = RD_FIRST;
      rd_x_nx     = '0;
    end else begin
      case (rd_state)
        RD_FIRST: begin
          if (rd_x == rd_last) begin
            rd_state_nx = RD_SECOND;
            rd_x_nx     = '0;
          end
        end
        RD_SECOND: begin
          if (rd_x == rd_last) begin
            rd_state_nx = RD_HOLD;
            rd_x_nx     = rd_x;
          end
        end
        default: begin
          rd_x_nx = rd_x;
        end
      endcase
    end
  end

  // Stage 1 lines up with the RAM output; stage 2 is the output register.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      vld_d1 <= 1'b0;
      ph_d1  <= 1'b0;
      hs_d1  <= 1'b1;
      vs_d1  <= 1'b1;
      hs_out <= 1'b1;
      vs_out <= 1'b1;
      rgb_o  <= '0;
    end else begin
      vld_d1 <= line_active;
      ph_d1  <= phase;
      hs_d1  <= ~line_active | (rd_x >= hs_width);
      vs_d1  <= vs_cap;
      hs_out <= hs_d1;
      vs_out <= vs_d1;
      if (!vld_d1) begin
        rgb_o <= '0;
      end else if (ph_d1 && scanlines) begin
        rgb_o <= scanline_dim(rgb_t'(rd_data));
      end else begin
        rgb_o <= rgb_t'(rd_data);
      end
    end
  end

  assign r_out = rgb_o.r;
  assign g_out = rgb_o.g;
  assign b_out = rgb_o.b;

endmodule

// File: tb/tb_laser500_scandoubler.sv
// tb/tb_laser500_scandoubler.sv - randomized line-doubler bench against a line-level reference model
module tb_laser500_scandoubler;

  localparam int CW = 6;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          ce_pix;
  logic          hs_in;
  logic          vs_in;
  logic [CW-1:0] r_in, g_in, b_in;
  logic          scanlines;
  logic          hs_out;
  logic          vs_out;
  logic [CW-1:0] r_out, g_out, b_out;
  logic [9:0]    line_len;

  always #5 CLK = ~CLK;

  laser500_scandoubler dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .ce_pix    (ce_pix),
    .hs_in     (hs_in),
    .vs_in     (vs_in),
    .r_in      (r_in),
    .g_in      (g_in),
    .b_in      (b_in),
    .scanlines (scanlines),
    .hs_out    (hs_out),
    .vs_out    (vs_out),
    .r_out     (r_out),
    .g_out     (g_out),
    .b_out     (b_out),
    .line_len  (line_len)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Reference: each input line is stored whole; output position p after a line start
  // is replay 0 for p < L, replay 1 for p < 2L, then the last pixel, shown 2 clocks later.
  typedef struct {
    bit idle;
    int pix;
    bit ph;
    bit hs;
    bit vs;
  } rec_t;

  int   cur_buf  [1024];
  int   line_buf [1024];
  int   m_cnt, m_hw, m_L, m_W, m_B, m_edge;
  bit   m_started, m_hs_prev, m_vs;
  rec_t rec1, rec2;
  bit   rst1;

  function automatic int dim(int p);
    int r, g, b;
    r = (p >> 12) & 63;
    g = (p >> 6) & 63;
    b = p & 63;
    return ((r / 2) << 12) | ((g / 2) << 6) | (b / 2);
  endfunction

  task automatic step();
    rec_t r0, ex;
    bit   rst0;
    int   p, idx, pix, exp_pix;
    @(posedge CLK);
    m_edge++;
    rst0 = !RESET;
    pix  = int'({r_in, g_in, b_in});
    if (rst0) begin
      m_started = 0; m_hs_prev = 1; m_L = 0; m_W = 0; m_vs = 1; m_cnt = 0; m_hw = 0;
    end else if (ce_pix) begin
      if (m_hs_prev && !hs_in) begin
        if (m_started) begin
          for (int i = 0; i < m_cnt; i++) line_buf[i] = cur_buf[i];
          m_L = m_cnt;
          m_W = m_hw;
        end else begin
          m_L = 0;
        end
        m_started  = 1;
        m_vs       = vs_in;
        m_B        = m_edge;
        cur_buf[0] = pix;
        m_cnt      = 1;
        m_hw       = 1;
      end else begin
        if (m_started && m_cnt < 1023) begin
          cur_buf[m_cnt] = pix;
          m_cnt++;
        end
        if (!hs_in && m_hw < 1023) m_hw++;
      end
      m_hs_prev = hs_in;
    end

    r0.vs = m_vs;
    if (rst0 || m_L == 0) begin
      r0.idle = 1; r0.pix = 0; r0.ph = 0; r0.hs = 1;
    end else begin
      p = m_edge - m_B;
      if (p < m_L) begin
        idx = p; r0.ph = 0;
      end else if (p < 2 * m_L) begin
        idx = p - m_L; r0.ph = 1;
      end else begin
        idx = m_L - 1; r0.ph = 1;
      end
      r0.idle = 0;
      r0.pix  = line_buf[idx];
      r0.hs   = (idx >= m_W);
    end

    ex = rec2;
    if (rst0 || rst1) begin
      ex.idle = 1; ex.hs = 1; ex.vs = 1;
    end
    if (ex.idle) exp_pix = 0;
    else if (ex.ph && scanlines) exp_pix = dim(ex.pix);
    else exp_pix = ex.pix;

    rec2 = rec1;
    rec1 = r0;
    rst1 = rst0;

    #1;
    check("rgb", {14'd0, r_out, g_out, b_out}, exp_pix);
    check("sync", {30'd0, hs_out, vs_out}, {30'd0, ex.hs, ex.vs});
    check("line_len", {22'd0, line_len}, m_L);
  endtask

  task automatic send_line(input int n, input int hlow, input logic vs, input int mode,
                           input int sl_mode, input int exp_len, input int rst_at);
    logic [17:0] px;
    logic [5:0]  xl;
    for (int x = 0; x < n; x++) begin
      xl = x[5:0];
      case (mode)
        0:       px = {xl, xl, xl};
        1:       px = {3{6'h3f}};
        default: px = 18'($urandom);
      endcase
      hs_in = (x < hlow) ? 1'b0 : 1'b1;
      vs_in = vs;
      {r_in, g_in, b_in} = px;
      for (int h = 0; h < 2; h++) begin
        ce_pix = (h == 0);
        if (sl_mode == 2) begin
          if ($urandom_range(0, 63) == 0) scanlines = ~scanlines;
        end else begin
          scanlines = (sl_mode == 1);
        end
        RESET = !(rst_at >= 0 && x >= rst_at && x < rst_at + 2);
        step();
      end
      if (x == 0 && exp_len >= 0) check("len_at_boundary", {22'd0, line_len}, exp_len);
      if (rst_at >= 0 && x == rst_at + 1) begin
        check("rst_hs", {31'd0, hs_out}, 1);
        check("rst_vs", {31'd0, vs_out}, 1);
        check("rst_rgb", {14'd0, r_out, g_out, b_out}, 0);
        check("rst_len", {22'd0, line_len}, 0);
      end
    end
  endtask

  initial begin
    int n, prev;
    RESET = 1'b0; ce_pix = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    r_in = '0; g_in = '0; b_in = '0; scanlines = 1'b0;
    m_edge = 0; m_B = 0; m_started = 0; m_hs_prev = 1; m_vs = 1;
    m_L = 0; m_W = 0; m_cnt = 0; m_hw = 0;
    rec1 = '{idle: 1, pix: 0, ph: 0, hs: 1, vs: 1};
    rec2 = rec1;
    rst1 = 1;

    repeat (4) step();
    check("init_hs", {31'd0, hs_out}, 1);
    check("init_vs", {31'd0, vs_out}, 1);
    check("init_rgb", {14'd0, r_out, g_out, b_out}, 0);
    check("init_len", {22'd0, line_len}, 0);

    send_line(300, 0, 1'b1, 2, 0, -1, -1);
    send_line(946, 70, 1'b1, 0, 0, 0, -1);
    repeat (2) send_line(946, 70, 1'b1, 0, 0, 946, -1);
    repeat (2) send_line(946, 70, 1'b1, 1, 1, 946, -1);
    send_line(946, 70, 1'b1, 1, 0, 946, -1);
    send_line(946, 70, 1'b1, 2, 2, 946, 400);
    send_line(946, 70, 1'b1, 0, 0, 0, -1);
    send_line(946, 70, 1'b0, 0, 1, 946, -1);
    send_line(946, 70, 1'b0, 2, 2, 946, -1);
    send_line(946, 70, 1'b1, 2, 0, 946, -1);
    send_line(1200, 70, 1'b1, 0, 1, 946, -1);
    send_line(946, 70, 1'b1, 0, 0, 1023, -1);
    send_line(500, 70, 1'b1, 2, 1, 946, -1);
    send_line(946, 70, 1'b1, 0, 0, 500, -1);

    prev = 946;
    repeat (8) begin
      n = $urandom_range(200, 1100);
      send_line(n, $urandom_range(10, 100), 1'($urandom_range(0, 1)), 2, 2,
                (prev > 1023) ? 1023 : prev, -1);
      prev = n;
    end
    send_line(946, 70, 1'b1, 0, 0, (prev > 1023) ? 1023 : prev, -1);
    send_line(20, 5, 1'b1, 0, 0, 946, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
